// File: rtl/channel_arbiter.sv
// channel_arbiter: round-robin pick among bank scheduler requests into a one-deep command slot,
// with an idle gap on each read/write direction change. Build macro ARB_TYPE_GROUPING_EN adds same-type grouping.
module channel_arbiter #(
  parameter int BANKS       = 16,
  parameter int REQ_SIZE    = 32,
  parameter int VALID_POS   = 0,
  parameter int TYPE_POS    = 1,
  parameter int MAX_STREAK  = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [BANKS-1:0][REQ_SIZE-1:0] req,
  output logic [BANKS-1:0]               grant_o,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [REQ_SIZE-1:0]            cmd_data,
  output logic [$clog2(BANKS)-1:0]       cmd_bank
);

  localparam int BW = $clog2(BANKS);
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0]    TURN_LOAD = TW'(TURN_CYCLES - 1);
  localparam logic [BANKS-1:0] ONE_HOT0  = {{(BANKS-1){1'b0}}, 1'b1};

  if ((MAX_STREAK < 1) || (TURN_CYCLES < 1) || ((BANKS & (BANKS - 1)) != 0)) begin : g_bad_params
    $error("channel_arbiter: illegal parameter set");
  end

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_TURN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [TW-1:0]         r_turn_cnt;
  logic [BW-1:0]         r_rr_ptr;
  logic                  r_last_type;
  logic                  r_has_issued;
  logic                  r_cmd_valid;
  logic [REQ_SIZE-1:0]   r_cmd_data;
  logic [BW-1:0]         r_cmd_bank;

  logic [BANKS-1:0]      w_valid;
  logic [BANKS-1:0]      w_type;
  logic [BANKS-1:0]      w_cand;
  logic [BANKS-1:0]      w_rot;
  logic [BW-1:0]         w_win_off;
  logic [BW-1:0]         w_win;
  logic                  w_found;
  logic                  w_win_type;
  logic                  w_slot_free;
  logic                  w_arb_ok;
  logic                  w_same_dir;
  logic                  w_do_grant;
  logic                  w_do_turn;

  // Pull the valid and type flags out of every request word.
  always_comb begin
    w_valid = '0;
    w_type  = '0;
    for (int b = 0; b < BANKS; b++) begin
      w_valid[b] = req[b][VALID_POS];
      w_type[b]  = req[b][TYPE_POS];
    end
  end

`ifdef ARB_TYPE_GROUPING_EN
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0]    r_streak;
  logic [BANKS-1:0] w_same;

  // Stay on the current direction until the streak is used up or it runs dry.
  assign w_same = w_valid & ~(w_type ^ {BANKS{r_last_type}});
  assign w_cand = ((|w_same) && (r_streak < STREAK_MAX)) ? w_same : w_valid;
`else
  assign w_cand = w_valid;
`endif

  // Rotate candidates so bit 0 is rr_ptr, then find the lowest set offset.
  always_comb begin
    w_rot     = '0;
    w_win_off = '0;
    for (int k = 0; k < BANKS; k++) begin
      w_rot[k] = w_cand[r_rr_ptr + BW'(k)];
    end
    for (int i = BANKS - 1; i >= 0; i--) begin
      w_win_off = w_rot[i] ? BW'(i) : w_win_off;
    end
  end

  assign w_found     = |w_cand;
  assign w_win       = r_rr_ptr + w_win_off;
  assign w_win_type  = w_type[w_win];
  assign w_slot_free = !r_cmd_valid || cmd_ready;
  assign w_arb_ok    = (r_state == ST_ISSUE) && w_slot_free && w_found;
  assign w_same_dir  = (w_win_type == r_last_type) || !r_has_issued;
  assign w_do_grant  = w_arb_ok && w_same_dir;
  assign w_do_turn   = w_arb_ok && !w_same_dir;

  // Grant pulse is gated by rst_n so nothing is popped while reset is held.
  always_comb begin
    if (rst_n && w_do_grant) begin
      grant_o = ONE_HOT0 << w_win;
    end else begin
      grant_o = '0;
    end
  end

  // Arbitration state: pointer, direction tracking and the turnaround FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ISSUE;
      r_turn_cnt   <= '0;
      r_rr_ptr     <= '0;
      r_last_type  <= 1'b0;
      r_has_issued <= 1'b0;
`ifdef ARB_TYPE_GROUPING_EN
      r_streak     <= '0;
`endif
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_do_grant) begin
            r_rr_ptr     <= w_win + BW'(1);
            r_has_issued <= 1'b1;
            r_last_type  <= w_win_type;
`ifdef ARB_TYPE_GROUPING_EN
            if (w_win_type == r_last_type) begin
              r_streak <= (r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + SW'(1);
            end else begin
              r_streak <= SW'(1);
            end
`endif
          end else if (w_do_turn) begin
            r_state     <= ST_TURN;
            r_turn_cnt  <= TURN_LOAD;
            r_last_type <= w_win_type;
`ifdef ARB_TYPE_GROUPING_EN
            r_streak    <= '0;
`endif
          end
        end
        ST_TURN: begin
          if (r_turn_cnt == '0) begin
            r_state <= ST_ISSUE;
          end else begin
            r_turn_cnt <= r_turn_cnt - TW'(1);
          end
        end
        default: begin
          r_state <= ST_ISSUE;
        end
      endcase
    end
  end

  // Command slot: capture on grant, otherwise drain when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_cmd_bank  <= '0;
    end else if (w_do_grant) begin
      r_cmd_valid <= 1'b1;
      r_cmd_data  <= req[w_win];
      r_cmd_bank  <= w_win;
    end else if (cmd_ready) begin
      r_cmd_valid <= 1'b0;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_data  = r_cmd_data;
  assign cmd_bank  = r_cmd_bank;

endmodule

// File: tb/tb_channel_arbiter.sv
// Self-checking bench for channel_arbiter: directed vector table, hand sequences and a randomized run
// against a rule-level reference model.
module tb_channel_arbiter;

  localparam int BANKS       = 16;
  localparam int REQ_SIZE    = 32;
  localparam int VALID_POS   = 0;
  localparam int TYPE_POS    = 1;
  localparam int MAX_STREAK  = 8;
  localparam int TURN_CYCLES = 2;
  localparam int BW          = 4;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           cmd_ready = 1'b0;
  logic [BANKS-1:0][REQ_SIZE-1:0] req;
  logic [BANKS-1:0]               grant_o;
  logic                           cmd_valid;
  logic [REQ_SIZE-1:0]            cmd_data;
  logic [BW-1:0]                  cmd_bank;

  int n_checks = 0;
  int n_errors = 0;

  channel_arbiter #(
    .BANKS(BANKS), .REQ_SIZE(REQ_SIZE), .VALID_POS(VALID_POS), .TYPE_POS(TYPE_POS),
    .MAX_STREAK(MAX_STREAK), .TURN_CYCLES(TURN_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant_o(grant_o),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_bank(cmd_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [REQ_SIZE-1:0] mkword(input int b, input logic t, input logic v);
    return {24'(b * 37 + 5), 6'b000000, t, v};
  endfunction

  // ---------------- reference model (rule level) ----------------
  int   m_rr, m_streak, m_turn_left, m_sb;
  bit   m_last, m_issued, m_turn, m_sv;
  logic [REQ_SIZE-1:0] m_sd;

  task automatic model_reset();
    m_rr = 0; m_streak = 0; m_turn_left = 0; m_sb = 0;
    m_last = 1'b0; m_issued = 1'b0; m_turn = 1'b0; m_sv = 1'b0; m_sd = '0;
  endtask

  task automatic model_decide(output bit g, output bit tr, output int w);
    bit any_same, restrict_same;
    int b;
    g = 1'b0; tr = 1'b0; w = -1; any_same = 1'b0;
    for (int i = 0; i < BANKS; i++)
      if (req[i][VALID_POS] && (req[i][TYPE_POS] == m_last)) any_same = 1'b1;
`ifdef ARB_TYPE_GROUPING_EN
    restrict_same = any_same && (m_streak < MAX_STREAK);
`else
    restrict_same = 1'b0;
`endif
    for (int k = 0; k < BANKS; k++) begin
      b = (m_rr + k) % BANKS;
      if (w < 0 && req[b][VALID_POS] && (!restrict_same || req[b][TYPE_POS] == m_last)) w = b;
    end
    if (!m_turn && (!m_sv || cmd_ready) && w >= 0) begin
      if (req[w][TYPE_POS] == m_last || !m_issued) g = 1'b1;
      else tr = 1'b1;
    end
  endtask

  task automatic model_step(input bit g, input bit tr, input int w);
    bit wt;
    wt = (w >= 0) ? req[w][TYPE_POS] : 1'b0;
    if (m_turn) begin
      if (m_turn_left == 0) m_turn = 1'b0;
      else m_turn_left--;
    end else if (g) begin
      if (wt == m_last) m_streak = (m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1;
      else m_streak = 1;
      m_last = wt; m_issued = 1'b1; m_rr = (w + 1) % BANKS;
    end else if (tr) begin
      m_turn = 1'b1; m_turn_left = TURN_CYCLES - 1; m_last = wt; m_streak = 0;
    end
    if (g) begin
      m_sv = 1'b1; m_sd = req[w]; m_sb = w;
    end else if (cmd_ready) begin
      m_sv = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0] vmask;
    logic [15:0] tmask;
    logic        ready;
    logic [15:0] exp_grant;
    logic        exp_cv;
    logic [3:0]  exp_cb;
    logic        exp_ct;
  } vec_t;

  vec_t tbl[13];

  initial begin
    bit g, tr;
    int w;
    logic [BANKS-1:0] eg;

    tbl[0]  = '{16'h0208, 16'h0000, 1'b1, 16'h0008, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{16'h0200, 16'h0000, 1'b1, 16'h0200, 1'b1, 4'd3, 1'b0};
    tbl[2]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'd9, 1'b0};
    tbl[3]  = '{16'h0020, 16'h0000, 1'b0, 16'h0020, 1'b0, 4'd9, 1'b0};
    tbl[4]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd5, 1'b0};
    tbl[5]  = '{16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'd5, 1'b0};
    tbl[6]  = '{16'h0040, 16'h0000, 1'b1, 16'h0040, 1'b1, 4'd5, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'd6, 1'b0};
    tbl[8]  = '{16'h0004, 16'h0004, 1'b1, 16'h0000, 1'b0, 4'd6, 1'b0};
    tbl[9]  = '{16'h0004, 16'h0004, 1'b1, 16'h0000, 1'b0, 4'd6, 1'b0};
    tbl[10] = '{16'h0004, 16'h0004, 1'b1, 16'h0000, 1'b0, 4'd6, 1'b0};
    tbl[11] = '{16'h0004, 16'h0004, 1'b1, 16'h0004, 1'b0, 4'd6, 1'b0};
    tbl[12] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'd2, 1'b1};

    // Reset state while rst_n is held low
    req = '0;
    #12;
    check("reset_grant", 64'(grant_o), 64'h0);
    check("reset_cmd_valid", 64'(cmd_valid), 64'h0);
    check("reset_cmd_data", 64'(cmd_data), 64'h0);
    check("reset_cmd_bank", 64'(cmd_bank), 64'h0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      for (int b = 0; b < BANKS; b++) req[b] = mkword(b, tbl[i].tmask[b], tbl[i].vmask[b]);
      cmd_ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_grant", i), 64'(grant_o), 64'(tbl[i].exp_grant));
      check($sformatf("tbl%0d_cmd_valid", i), 64'(cmd_valid), 64'(tbl[i].exp_cv));
      check($sformatf("tbl%0d_cmd_bank", i), 64'(cmd_bank), 64'(tbl[i].exp_cb));
      if (tbl[i].exp_cv)
        check($sformatf("tbl%0d_cmd_data", i), 64'(cmd_data),
              64'(mkword(int'(tbl[i].exp_cb), tbl[i].exp_ct, 1'b1)));
      @(posedge clk);
      #1;
    end

    // Streak / turnaround: reads everywhere except a write on bank 8, all held valid
    pulse_reset();
    for (int b = 0; b < BANKS; b++) req[b] = mkword(b, (b == 8), 1'b1);
    cmd_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      eg = '0;
      if (c < 8) eg[c] = 1'b1;
      if (c == 11) eg[8] = 1'b1;
      @(negedge clk);
      check($sformatf("streak_c%0d_grant", c), 64'(grant_o), 64'(eg));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with a command in the slot, then a write grants without turnaround
    for (int b = 0; b < BANKS; b++) req[b] = mkword(b, 1'b1, (b == 4));
    cmd_ready = 1'b1;
    check("pre_reset_cmd_valid", 64'(cmd_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cmd_valid", 64'(cmd_valid), 64'h0);
    check("async_rst_grant", 64'(grant_o), 64'h0);
    check("async_rst_cmd_bank", 64'(cmd_bank), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_write_grant", 64'(grant_o), 64'h0010);
    @(posedge clk);
    #1;
    req = '0;
    @(negedge clk);
    check("post_rst_cmd_valid", 64'(cmd_valid), 64'h1);
    check("post_rst_cmd_bank", 64'(cmd_bank), 64'h4);
    check("post_rst_cmd_data", 64'(cmd_data), 64'(mkword(4, 1'b1, 1'b1)));
    check("post_rst_grant_idle", 64'(grant_o), 64'h0);

    // Randomized run against the reference model
    pulse_reset();
    for (int b = 0; b < BANKS; b++) begin
      req[b] = $urandom;
      req[b][VALID_POS] = 1'($urandom_range(0, 1));
      req[b][TYPE_POS]  = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cmd_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_decide(g, tr, w);
      eg = '0;
      if (g) eg[w] = 1'b1;
      check("rand_grant", 64'(grant_o), 64'(eg));
      check("rand_cmd_valid", 64'(cmd_valid), 64'(m_sv));
      if (m_sv) begin
        check("rand_cmd_data", 64'(cmd_data), 64'(m_sd));
        check("rand_cmd_bank", 64'(cmd_bank), 64'(m_sb));
      end
      @(posedge clk);
      model_step(g, tr, w);
      #1;
      for (int b = 0; b < BANKS; b++) begin
        if ((g && b == w) || (!req[b][VALID_POS] && $urandom_range(0, 3) == 0)) begin
          req[b] = $urandom;
          req[b][VALID_POS] = 1'($urandom_range(0, 1));
          if (cyc < 1500) req[b][TYPE_POS] = 1'($urandom_range(0, 1));
          else req[b][TYPE_POS] = ($urandom_range(0, 7) == 0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
